sdr_reply_send: RTL and testbench
=================================

Name: sdr_reply_send

Overview:
- Builds and transmits the UDP reply payloads on the port-1024 management protocol: discovery reply, erase-complete, and send-more (request next 256-byte programming block).
- Accepts requests from the management receiver and the EPCS programmer, arbitrates between them, and serialises one fixed-length payload per request.
- Streams bytes to the UDP/IP transmit path through a request/grant byte handshake.

Parameters:
- PAYLOAD_LEN, 60, bytes per reply payload; bytes beyond the defined fields are zero.
- GRANT_TIMEOUT, 1000000, tx_clock cycles to wait for udp_tx_enable before abandoning a packet.
- PROTO_VER, 8'h26, protocol version byte.

Ports:
- tx_clock  in  1  sole clock
- reset_n  in  1  asynchronous, active-low reset
- discovery_reply  in  1  level request from the receiver; held until discovery_ACK
- erase_done  in  1  one-cycle pulse: EPCS erase finished
- send_more  in  1  one-cycle pulse: EPCS FIFO can take another block
- running  in  1  radio streaming active
- local_mac  in  48  MAC placed in every reply
- board_id  in  8  board type
- code_version  in  8  firmware version
- sequence_number  in  32  last programming sequence number from the host
- discovery_ACK  out  1  one-cycle pulse: discovery request accepted
- sending_sync  out  1  high while a discovery reply is pending or in flight
- udp_tx_request  out  1  payload ready to send
- udp_tx_length  out  16  payload length, equal to PAYLOAD_LEN
- udp_tx_enable  in  1  grant; one byte consumed per high cycle
- udp_tx_data  out  8  current payload byte
- drop_count  out  8  saturating count of packets abandoned on timeout

Behaviour:
- Reset values:
  - All outputs 0, except udp_tx_length, which is PAYLOAD_LEN.
  - Pending flags clear, byte index 0, FSM in IDLE.
- Request capture:
  - Discovery is captured on the rising edge of discovery_reply, using a registered previous value. A level held high is never captured twice.
  - erase_done and send_more pulses set sticky pending flags.
  - A pulse arriving while a packet of the same type is pending or in flight is merged. No counter is kept.
- discovery_ACK pulses for one cycle in the cycle after the rising edge is captured.
- sending_sync goes high in that same cycle and stays high until the cycle after the last discovery byte is consumed, or until a timeout abandons the packet.
- Arbitration (IDLE, when any flag is pending): discovery > erase_done > send_more.
  - The winner's flag is cleared and its type is latched.
  - Transition IDLE -> REQ.
- REQ:
  - udp_tx_request = 1; udp_tx_data presents byte 0.
  - A wait counter starts at 0.
  - If udp_tx_enable is seen, go to SEND.
  - If the counter reaches GRANT_TIMEOUT-1 without a grant, drop request, increment drop_count (saturating at 255), and return to IDLE.
- SEND:
  - Each cycle udp_tx_enable=1, the index advances and udp_tx_data shows the next byte in the following cycle. Byte k is therefore valid during the k-th enable cycle.
  - udp_tx_enable low during SEND stalls the index and does not abort.
  - When byte PAYLOAD_LEN-1 is consumed, udp_tx_request drops the next cycle and the FSM moves to DONE.
- DONE: one idle cycle for inter-packet spacing, then IDLE. Pending requests are then re-arbitrated.
- Payload format (byte index: content):
  - 0-3: sequence_number, MSB first, for send_more; 0 for the other types.
  - 4: type. Discovery = 2 (3 if running was sampled high at arbitration); erase_done = 4; send_more = 5.
  - 5-10: local_mac, MSB first.
  - 11: board_id. 12: PROTO_VER. 13: code_version.
  - 14 to PAYLOAD_LEN-1: 0.
- Field inputs are sampled once at arbitration into a snapshot register. Changes mid-packet do not affect the bytes sent.
- Asynchronous reset mid-packet: udp_tx_request drops immediately and all pending requests are lost.

Decomposition:
- Shared package sdr_proto_pkg holds:
  - type codes REPLY_DISC_IDLE=2, REPLY_DISC_RUN=3, REPLY_ERASE_DONE=4, REPLY_SEND_MORE=5;
  - the management port constant 1024;
  - the FSM state enum (IDLE, REQ, SEND, DONE);
  - payload field offsets.
- One sub-module, sdr_reply_mux: a combinational byte selector from (type snapshot, field snapshot, index) to udp_tx_data.

Test Plan:
- Raise discovery_reply with running=0 and grant immediately. Expect discovery_ACK one cycle later, then 60 bytes with byte4=02, bytes5-10=local_mac, byte12=26, bytes14-59=00; sending_sync falls after byte 59.
- Hold discovery_reply high for 50 cycles. Expect exactly one discovery_ACK and one packet.
- Pulse erase_done and send_more in the same cycle as a discovery edge. Expect packets in order: type 02, type 04, type 05, each separated by at least one idle cycle.
- Send send_more with sequence_number=32'hDEADBEEF and toggle udp_tx_enable every other cycle. Expect bytes0-4 = DE AD BE EF 05, no byte skipped or repeated.
- Set GRANT_TIMEOUT=16 and never grant. Expect udp_tx_request to fall after 16 cycles and drop_count=1; sending_sync low; the next request is served normally.
- Assert reset_n low at byte 20. Expect udp_tx_request=0 immediately and, after release, IDLE with no packet sent.

Source files
------------

// File: rtl/sdr_proto_pkg.sv
// Shared definitions for the port-1024 management reply path:
// type codes, port number, FSM states and payload field layout.
package sdr_proto_pkg;

  // Reply type byte values
  localparam logic [7:0] REPLY_DISC_IDLE  = 8'd2;
  localparam logic [7:0] REPLY_DISC_RUN   = 8'd3;
  localparam logic [7:0] REPLY_ERASE_DONE = 8'd4;
  localparam logic [7:0] REPLY_SEND_MORE  = 8'd5;

  // UDP management port
  localparam logic [15:0] MGMT_PORT = 16'd1024;

  // Reply sender states
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_SEND,
    ST_DONE
  } reply_state_t;

  // Payload byte offsets
  localparam int OFF_SEQ   = 0;   // 4 bytes, MSB first
  localparam int OFF_TYPE  = 4;
  localparam int OFF_MAC   = 5;   // 6 bytes, MSB first
  localparam int OFF_BOARD = 11;
  localparam int OFF_PROTO = 12;
  localparam int OFF_CODE  = 13;
  localparam int OFF_PAD   = 14;  // zero fill from here to the end

  // Field snapshot taken at arbitration
  typedef struct packed {
    logic [31:0] seq;
    logic [47:0] mac;
    logic [7:0]  board_id;
    logic [7:0]  code_version;
  } reply_fields_t;

  function automatic logic is_discovery(input logic [7:0] t);
    return (t == REPLY_DISC_IDLE) || (t == REPLY_DISC_RUN);
  endfunction

endpackage

// File: rtl/sdr_reply_mux.sv
// Combinational payload byte selector: maps the latched reply type,
// field snapshot and byte index onto the outgoing payload byte.
import sdr_proto_pkg::*;

module sdr_reply_mux #(
  parameter int         PAYLOAD_LEN = 60,
  parameter int         IDX_W       = 6,
  parameter logic [7:0] PROTO_VER   = 8'h26
) (
  input  logic [7:0]       type_i,
  input  reply_fields_t    fields_i,
  input  logic [IDX_W-1:0] idx_i,
  output logic [7:0]       byte_o
);

  logic [7:0] payload [PAYLOAD_LEN];

  // Every payload position is wired to a fixed field slice or zero
  for (genvar gi = 0; gi < PAYLOAD_LEN; gi++) begin : g_byte
    if (gi < OFF_TYPE) begin : g_seq
      assign payload[gi] = fields_i.seq[8*(OFF_TYPE-1-gi) +: 8];
    end else if (gi == OFF_TYPE) begin : g_type
      assign payload[gi] = type_i;
    end else if (gi < OFF_BOARD) begin : g_mac
      assign payload[gi] = fields_i.mac[8*(OFF_BOARD-1-gi) +: 8];
    end else if (gi == OFF_BOARD) begin : g_board
      assign payload[gi] = fields_i.board_id;
    end else if (gi == OFF_PROTO) begin : g_proto
      assign payload[gi] = PROTO_VER;
    end else if (gi == OFF_CODE) begin : g_code
      assign payload[gi] = fields_i.code_version;
    end else begin : g_pad
      assign payload[gi] = 8'h00;
    end
  end

  // Out-of-range indices read as zero
  always_comb begin
    byte_o = 8'h00;
    if (idx_i < IDX_W'(PAYLOAD_LEN)) begin
      byte_o = payload[idx_i];
    end
  end

endmodule

// File: rtl/sdr_reply_send.sv
// Management reply sender: captures discovery / erase-done / send-more
// requests, arbitrates them, and streams one fixed-length payload per
// request through the UDP transmit request/grant byte handshake.
import sdr_proto_pkg::*;

module sdr_reply_send #(
  parameter int         PAYLOAD_LEN   = 60,
  parameter int         GRANT_TIMEOUT = 1000000,
  parameter logic [7:0] PROTO_VER     = 8'h26
) (
  input  logic        tx_clock,
  input  logic        reset_n,
  input  logic        discovery_reply,
  input  logic        erase_done,
  input  logic        send_more,
  input  logic        running,
  input  logic [47:0] local_mac,
  input  logic [7:0]  board_id,
  input  logic [7:0]  code_version,
  input  logic [31:0] sequence_number,
  output logic        discovery_ACK,
  output logic        sending_sync,
  output logic        udp_tx_request,
  output logic [15:0] udp_tx_length,
  input  logic        udp_tx_enable,
  output logic [7:0]  udp_tx_data,
  output logic [7:0]  drop_count
);

  localparam int IDX_W  = $clog2(PAYLOAD_LEN);
  localparam int WAIT_W = $clog2(GRANT_TIMEOUT);

  reply_state_t      state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [7:0]        type_q, type_d;
  reply_fields_t     fields_q, fields_d;
  logic [7:0]        drop_q, drop_d;
  logic              disc_prev_q, disc_prev_d;
  logic              disc_pend_q, disc_pend_d;
  logic              erase_pend_q, erase_pend_d;
  logic              more_pend_q, more_pend_d;
  logic              ack_q, ack_d;
  logic              sync_q, sync_d;

  logic       take_disc, take_erase, take_more;
  logic       active, disc_edge;
  logic [7:0] mux_byte;

  assign active    = (state_q == ST_REQ) || (state_q == ST_SEND);
  assign disc_edge = discovery_reply & ~disc_prev_q;

  // State and request registers; reset abandons everything in flight
  always_ff @(posedge tx_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      wait_q       <= '0;
      type_q       <= '0;
      fields_q     <= '0;
      drop_q       <= '0;
      disc_prev_q  <= 1'b0;
      disc_pend_q  <= 1'b0;
      erase_pend_q <= 1'b0;
      more_pend_q  <= 1'b0;
      ack_q        <= 1'b0;
      sync_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      wait_q       <= wait_d;
      type_q       <= type_d;
      fields_q     <= fields_d;
      drop_q       <= drop_d;
      disc_prev_q  <= disc_prev_d;
      disc_pend_q  <= disc_pend_d;
      erase_pend_q <= erase_pend_d;
      more_pend_q  <= more_pend_d;
      ack_q        <= ack_d;
      sync_q       <= sync_d;
    end
  end

  // Arbitration, handshake sequencing and pending-flag bookkeeping
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    wait_d     = wait_q;
    type_d     = type_q;
    fields_d   = fields_q;
    drop_d     = drop_q;
    take_disc  = 1'b0;
    take_erase = 1'b0;
    take_more  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (disc_pend_q) begin
          take_disc = 1'b1;
          type_d    = running ? REPLY_DISC_RUN : REPLY_DISC_IDLE;
        end else if (erase_pend_q) begin
          take_erase = 1'b1;
          type_d     = REPLY_ERASE_DONE;
        end else if (more_pend_q) begin
          take_more = 1'b1;
          type_d    = REPLY_SEND_MORE;
        end
        if (disc_pend_q || erase_pend_q || more_pend_q) begin
          state_d               = ST_REQ;
          idx_d                 = '0;
          wait_d                = '0;
          // Sequence number only belongs in send-more replies
          fields_d.seq          = take_more ? sequence_number : 32'h0;
          fields_d.mac          = local_mac;
          fields_d.board_id     = board_id;
          fields_d.code_version = code_version;
        end
      end
      ST_REQ: begin
        if (udp_tx_enable) begin
          // First grant cycle consumes byte 0
          idx_d   = idx_q + 1'b1;
          state_d = ST_SEND;
        end else if (wait_q == WAIT_W'(GRANT_TIMEOUT - 1)) begin
          state_d = ST_IDLE;
          if (drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
          end
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_SEND: begin
        if (udp_tx_enable) begin
          if (idx_q == IDX_W'(PAYLOAD_LEN - 1)) begin
            idx_d   = '0;
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // New requests merge into an identical one already pending or in flight
    disc_prev_d  = discovery_reply;
    disc_pend_d  = (disc_pend_q & ~take_disc) |
                   (disc_edge & ~(disc_pend_q | (active & is_discovery(type_q))));
    erase_pend_d = (erase_pend_q & ~take_erase) |
                   (erase_done & ~(erase_pend_q | (active & (type_q == REPLY_ERASE_DONE))));
    more_pend_d  = (more_pend_q & ~take_more) |
                   (send_more & ~(more_pend_q | (active & (type_q == REPLY_SEND_MORE))));

    ack_d  = disc_edge;
    sync_d = disc_pend_d |
             (is_discovery(type_d) && ((state_d == ST_REQ) || (state_d == ST_SEND)));
  end

  sdr_reply_mux #(
    .PAYLOAD_LEN (PAYLOAD_LEN),
    .IDX_W       (IDX_W),
    .PROTO_VER   (PROTO_VER)
  ) u_mux (
    .type_i   (type_q),
    .fields_i (fields_q),
    .idx_i    (idx_q),
    .byte_o   (mux_byte)
  );

  assign discovery_ACK  = ack_q;
  assign sending_sync   = sync_q;
  assign udp_tx_request = active;
  assign udp_tx_length  = 16'(PAYLOAD_LEN);
  assign udp_tx_data    = active ? mux_byte : 8'h00;
  assign drop_count     = drop_q;

endmodule

// File: tb/tb_sdr_reply_send.sv
// Scoreboard bench for sdr_reply_send: stimulus pushes expected packets,
// a sink process grants bytes and compares them against a payload model.
module tb_sdr_reply_send;

  localparam int LEN = 60;
  localparam int TO  = 16;

  localparam logic [1:0] K_DISC  = 2'd0;
  localparam logic [1:0] K_ERASE = 2'd1;
  localparam logic [1:0] K_MORE  = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic        run;
    logic [31:0] seq;
    logic [47:0] mac;
    logic [7:0]  board;
    logic [7:0]  code;
  } pkt_t;

  logic        tx_clock = 1'b0;
  logic        reset_n;
  logic        discovery_reply, erase_done, send_more, running;
  logic [47:0] local_mac;
  logic [7:0]  board_id, code_version;
  logic [31:0] sequence_number;
  logic        discovery_ACK, sending_sync, udp_tx_request;
  logic [15:0] udp_tx_length;
  logic        udp_tx_enable;
  logic [7:0]  udp_tx_data, drop_count;

  int   checks = 0;
  int   errors = 0;
  pkt_t exp_q[$];
  int   mode = 0;      // 0 always grant, 1 alternate, 2 random, 3 never
  int   mon_idx = 0;

  sdr_reply_send #(
    .PAYLOAD_LEN   (LEN),
    .GRANT_TIMEOUT (TO),
    .PROTO_VER     (8'h26)
  ) dut (
    .tx_clock        (tx_clock),
    .reset_n         (reset_n),
    .discovery_reply (discovery_reply),
    .erase_done      (erase_done),
    .send_more       (send_more),
    .running         (running),
    .local_mac       (local_mac),
    .board_id        (board_id),
    .code_version    (code_version),
    .sequence_number (sequence_number),
    .discovery_ACK   (discovery_ACK),
    .sending_sync    (sending_sync),
    .udp_tx_request  (udp_tx_request),
    .udp_tx_length   (udp_tx_length),
    .udp_tx_enable   (udp_tx_enable),
    .udp_tx_data     (udp_tx_data),
    .drop_count      (drop_count)
  );

  initial forever #5 tx_clock = ~tx_clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference payload: byte k of a reply as described by the field layout
  function automatic logic [7:0] exp_byte(input pkt_t p, input int k);
    logic [31:0] t32;
    logic [47:0] t48;
    if (k < 4) begin
      t32 = (p.kind == K_MORE) ? (p.seq >> (8 * (3 - k))) : 32'd0;
      return t32[7:0];
    end
    if (k == 4) begin
      if (p.kind == K_DISC)  return p.run ? 8'd3 : 8'd2;
      if (p.kind == K_ERASE) return 8'd4;
      return 8'd5;
    end
    if (k <= 10) begin
      t48 = p.mac >> (8 * (10 - k));
      return t48[7:0];
    end
    if (k == 11) return p.board;
    if (k == 12) return 8'h26;
    if (k == 13) return p.code;
    return 8'h00;
  endfunction

  function automatic pkt_t snap(input logic [1:0] kind);
    pkt_t p;
    p.kind  = kind;
    p.run   = running;
    p.seq   = sequence_number;
    p.mac   = local_mac;
    p.board = board_id;
    p.code  = code_version;
    return p;
  endfunction

  // Sink: grants bytes per mode, checks each consumed byte and packet gaps
  initial begin
    logic       en, tog, gap_chk, gap_disc, more_disc;
    logic [7:0] eb;
    tog = 1'b0; gap_chk = 1'b0; gap_disc = 1'b0;
    udp_tx_enable = 1'b0;
    forever begin
      @(negedge tx_clock);
      if (!reset_n) begin
        exp_q.delete();
        mon_idx = 0;
        gap_chk = 1'b0;
        udp_tx_enable = 1'b0;
      end else begin
        if (gap_chk) begin
          chk("gap_request_low", udp_tx_request, 1'b0);
          if (gap_disc) chk("sync_fall", sending_sync, 1'b0);
          gap_chk = 1'b0;
        end
        en = 1'b0;
        if (udp_tx_request) begin
          case (mode)
            0: en = 1'b1;
            1: begin tog = ~tog; en = tog; end
            2: en = 1'($urandom_range(0, 1));
            default: en = 1'b0;
          endcase
        end
        if (udp_tx_request && en) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte: got %0h with no packet expected", udp_tx_data);
          end else begin
            eb = exp_byte(exp_q[0], mon_idx);
            chk($sformatf("byte%0d_type%0d", mon_idx, exp_q[0].kind), udp_tx_data, eb);
            mon_idx++;
            if (mon_idx == LEN) begin
              gap_disc = (exp_q[0].kind == K_DISC);
              void'(exp_q.pop_front());
              more_disc = 1'b0;
              foreach (exp_q[i]) if (exp_q[i].kind == K_DISC) more_disc = 1'b1;
              gap_disc = gap_disc & ~more_disc;
              mon_idx = 0;
              gap_chk = 1'b1;
            end
          end
        end
        udp_tx_enable = en;
      end
    end
  end

  task automatic scramble();
    local_mac       = {16'($urandom), 32'($urandom)};
    board_id        = 8'($urandom);
    code_version    = 8'($urandom);
    sequence_number = $urandom;
    running         = 1'($urandom_range(0, 1));
  endtask

  task automatic req_disc(input bit push);
    int n;
    discovery_reply = 1'b1;
    if (push) exp_q.push_back(snap(K_DISC));
    n = 0;
    do begin
      @(negedge tx_clock);
      n++;
    end while (!discovery_ACK && n < 5);
    chk("ack_latency", 64'(n), 64'd1);
    chk("sync_on_ack", sending_sync, 1'b1);
    discovery_reply = 1'b0;
  endtask

  task automatic pulse(input logic [1:0] kind, input bit push);
    if (kind == K_ERASE) erase_done = 1'b1; else send_more = 1'b1;
    if (push) exp_q.push_back(snap(kind));
    @(negedge tx_clock);
    erase_done = 1'b0;
    send_more  = 1'b0;
  endtask

  task automatic wait_req_high();
    int n = 0;
    while (!udp_tx_request && n < 20) begin
      @(negedge tx_clock);
      n++;
    end
    chk("request_start", udp_tx_request, 1'b1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || udp_tx_request) && n < 3000) begin
      @(negedge tx_clock);
      n++;
    end
    chk("drain_pending", 64'(exp_q.size()), 64'd0);
    repeat (3) @(negedge tx_clock);
  endtask

  // Stimulus
  initial begin
    int n;
    logic [1:0] k;
    reset_n = 1'b0;
    discovery_reply = 1'b0; erase_done = 1'b0; send_more = 1'b0;
    scramble();
    running = 1'b0;
    repeat (3) @(negedge tx_clock);
    chk("rst_request", udp_tx_request, 1'b0);
    chk("rst_length", udp_tx_length, 16'd60);
    chk("rst_data", udp_tx_data, 8'h00);
    chk("rst_ack", discovery_ACK, 1'b0);
    chk("rst_sync", sending_sync, 1'b0);
    chk("rst_drop", drop_count, 8'h00);
    reset_n = 1'b1;
    repeat (2) @(negedge tx_clock);

    // Discovery, not running, immediate grant
    mode = 0;
    running = 1'b0;
    req_disc(1);
    wait_idle();

    // Held request level yields one ACK and one packet
    scramble();
    discovery_reply = 1'b1;
    exp_q.push_back(snap(K_DISC));
    n = 0;
    repeat (50) begin
      @(negedge tx_clock);
      if (discovery_ACK) n++;
    end
    chk("held_ack_count", 64'(n), 64'd1);
    discovery_reply = 1'b0;
    wait_idle();

    // Three requests in one cycle: priority order disc, erase, more
    scramble();
    discovery_reply = 1'b1; erase_done = 1'b1; send_more = 1'b1;
    exp_q.push_back(snap(K_DISC));
    exp_q.push_back(snap(K_ERASE));
    exp_q.push_back(snap(K_MORE));
    @(negedge tx_clock);
    chk("multi_ack", discovery_ACK, 1'b1);
    erase_done = 1'b0; send_more = 1'b0; discovery_reply = 1'b0;
    wait_idle();

    // Send-more with known sequence number and alternating grant
    mode = 1;
    sequence_number = 32'hDEADBEEF;
    pulse(K_MORE, 1);
    wait_idle();

    // Grant never arrives: abandon after TO cycles
    mode = 3;
    scramble();
    req_disc(0);
    wait_req_high();
    n = 0;
    while (udp_tx_request && n < 100) begin
      n++;
      @(negedge tx_clock);
    end
    chk("timeout_cycles", 64'(n), 64'(TO));
    chk("drop_after_timeout", drop_count, 8'd1);
    chk("sync_after_timeout", sending_sync, 1'b0);
    mode = 0;
    pulse(K_ERASE, 1);
    wait_idle();

    // Random single requests; fields scrambled once the packet is under way
    for (int it = 0; it < 20; it++) begin
      mode = $urandom_range(0, 2);
      scramble();
      k = 2'($urandom_range(0, 2));
      if (k == K_DISC) req_disc(1);
      else pulse(k, 1);
      wait_req_high();
      scramble();
      wait_idle();
    end

    // Reset in the middle of a packet, with another request pending
    mode = 0;
    scramble();
    pulse(K_MORE, 1);
    n = 0;
    while (mon_idx != 21 && n < 200) begin
      @(negedge tx_clock);
      #2;
      n++;
    end
    chk("reached_byte20", 64'(mon_idx), 64'd21);
    erase_done = 1'b1;
    @(negedge tx_clock);
    erase_done = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("request_async_drop", udp_tx_request, 1'b0);
    repeat (3) @(negedge tx_clock);
    reset_n = 1'b1;
    n = 0;
    repeat (40) begin
      @(negedge tx_clock);
      if (udp_tx_request) n++;
    end
    chk("no_packet_after_reset", 64'(n), 64'd0);
    chk("drop_after_reset", drop_count, 8'd0);
    chk("sync_after_reset", sending_sync, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
